// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around the shared memory port.
// The arbiter connects through the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          flush;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic [3:0]    d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          bus_err;
    logic          stall_req_if;
    logic          stall_req_mem;
    logic          mem_req;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  flush, if_req, if_addr, d_req, d_wen, d_addr, d_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata, bus_err,
               stall_req_if, stall_req_mem, mem_req, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output flush, if_req, if_addr, d_req, d_wen, d_addr, d_wdata,
               mem_addr_ok, mem_data_ok, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata, bus_err,
               stall_req_if, stall_req_mem, mem_req, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one transaction in flight, with fetch flush handling and a data-phase watchdog.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_ADDR,
        S_IF_DATA,
        S_D_ADDR,
        S_D_DATA
    } state_t;

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_grant_d;
    logic           r_drop;
    logic [WDW-1:0] r_wdog;
    logic [AW-1:0]  r_addr;
    logic [3:0]     r_wen;
    logic [DW-1:0]  r_wdata;
    logic           r_if_done;
    logic           r_d_done;
    logic [DW-1:0]  r_if_rdata;
    logic [DW-1:0]  r_d_rdata;
    logic           r_bus_err;

    logic w_if_eligible;
    logic w_d_eligible;
    logic w_pick_d;
    logic w_drop_now;
    logic w_timeout;
    logic w_in_data;
    logic w_grant_if;
    logic w_grant_d;
    logic w_complete_if;
    logic w_complete_d;
    logic w_abort_if;
    logic w_abort_d;
    logic w_set_drop;
    logic w_clr_drop;

    // A requester whose done is showing still holds req for this cycle, so it must not be re-granted.
    assign w_if_eligible = bus.if_req & ~r_if_done & ~bus.flush;
    assign w_d_eligible  = bus.d_req & ~r_d_done;
    assign w_pick_d      = w_d_eligible & (~w_if_eligible | (FAIR == 0) | ~r_last_grant_d);
    assign w_drop_now    = r_drop | bus.flush;
    assign w_timeout     = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);
    assign w_in_data     = (r_state == S_IF_DATA) || (r_state == S_D_DATA);

    always_comb begin
        w_next_state  = r_state;
        w_grant_if    = 1'b0;
        w_grant_d     = 1'b0;
        w_complete_if = 1'b0;
        w_complete_d  = 1'b0;
        w_abort_if    = 1'b0;
        w_abort_d     = 1'b0;
        w_set_drop    = 1'b0;
        w_clr_drop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_grant_d    = 1'b1;
                    w_next_state = S_D_ADDR;
                end else if (w_if_eligible) begin
                    w_grant_if   = 1'b1;
                    w_next_state = S_IF_ADDR;
                end
            end
            S_IF_ADDR: begin
                if (bus.mem_addr_ok) begin
                    w_next_state = S_IF_DATA;
                    w_set_drop   = bus.flush;
                end else if (bus.flush) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IF_DATA: begin
                if (bus.mem_data_ok) begin
                    w_next_state  = S_IDLE;
                    w_complete_if = ~w_drop_now;
                    w_clr_drop    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_abort_if   = ~w_drop_now;
                    w_clr_drop   = 1'b1;
                end else begin
                    w_set_drop = bus.flush;
                end
            end
            S_D_ADDR: begin
                if (bus.mem_addr_ok) begin
                    w_next_state = S_D_DATA;
                end
            end
            S_D_DATA: begin
                if (bus.mem_data_ok) begin
                    w_next_state = S_IDLE;
                    w_complete_d = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_abort_d    = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_grant_d <= 1'b0;
            r_drop         <= 1'b0;
            r_wdog         <= '0;
            r_addr         <= '0;
            r_wen          <= '0;
            r_wdata        <= '0;
            r_if_done      <= 1'b0;
            r_d_done       <= 1'b0;
            r_if_rdata     <= '0;
            r_d_rdata      <= '0;
            r_bus_err      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_if_done <= w_complete_if | w_abort_if;
            r_d_done  <= w_complete_d | w_abort_d;
            r_bus_err <= w_abort_if | w_abort_d;

            if (w_complete_if) begin
                r_if_rdata <= bus.mem_rdata;
            end else if (w_abort_if) begin
                r_if_rdata <= '0;
            end
            if (w_complete_d) begin
                r_d_rdata <= bus.mem_rdata;
            end else if (w_abort_d) begin
                r_d_rdata <= '0;
            end

            if (w_grant_d) begin
                r_addr         <= bus.d_addr;
                r_wen          <= bus.d_wen;
                r_wdata        <= bus.d_wdata;
                r_last_grant_d <= 1'b1;
            end else if (w_grant_if) begin
                r_addr         <= bus.if_addr;
                r_wen          <= '0;
                r_wdata        <= '0;
                r_last_grant_d <= 1'b0;
            end

            if (w_clr_drop) begin
                r_drop <= 1'b0;
            end else if (w_set_drop) begin
                r_drop <= 1'b1;
            end

            // Watchdog counts consecutive cycles spent in one data phase.
            if (w_in_data && (w_next_state == r_state)) begin
                r_wdog <= r_wdog + WDW'(1);
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign bus.mem_req       = (r_state == S_IF_ADDR) || (r_state == S_D_ADDR);
    assign bus.mem_wen       = r_wen;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.if_done       = r_if_done;
    assign bus.if_rdata      = r_if_rdata;
    assign bus.d_done        = r_d_done;
    assign bus.d_rdata       = r_d_rdata;
    assign bus.bus_err       = r_bus_err;
    assign bus.stall_req_if  = bus.if_req & ~r_if_done;
    assign bus.stall_req_mem = bus.d_req & ~r_d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a fair instance with a 4-cycle watchdog against a latency-programmable
// memory model, and a data-priority instance against an always-ready memory.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) busA ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) busB ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR(1), .TIMEOUT(4)) dutA (
        .clk(clk), .rst(rst), .bus(busA.slave)
    );
    mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR(0), .TIMEOUT(0)) dutB (
        .clk(clk), .rst(rst), .bus(busB.slave)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } grantT;

    typedef struct packed {
        logic [31:0] rdata;
        logic        checkData;
        logic        busErr;
    } doneT;

    grantT grantQA[$];
    grantT grantQB[$];
    doneT  ifDoneQA[$];
    doneT  dDoneQA[$];
    doneT  ifDoneQB[$];
    doneT  dDoneQB[$];

    int errorCount = 0;
    int checkCount = 0;
    int respAddrLat, respDataLat, respNoData;
    int respPhase = 0;
    int respCnt = 0;
    logic [31:0] respAddr;
    int dataOkCount = 0;
    int ifDoneSeenA = 0;
    logic prevReqA = 1'b0, prevIfDoneA = 1'b0, prevDDoneA = 1'b0;
    logic prevReqB = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memModel(input logic [31:0] addr);
        if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
        return addr ^ 32'h5A5A_0000;
    endfunction

    function automatic void pushGrantA(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        grantT g;
        g.addr = addr; g.wen = wen; g.wdata = wdata;
        grantQA.push_back(g);
    endfunction

    function automatic void pushGrantB(input logic [31:0] addr);
        grantT g;
        g.addr = addr; g.wen = 4'h0; g.wdata = 32'h0;
        grantQB.push_back(g);
    endfunction

    // Memory model for instance A: programmable address/data wait states, optional missing data phase.
    always @(negedge clk) begin
        if (rst) begin
            respPhase = 0;
            respCnt = 0;
            busA.mem_addr_ok = 1'b0;
            busA.mem_data_ok = 1'b0;
            busA.mem_rdata = 32'hBAD0_BAD0;
        end else begin
            busA.mem_addr_ok = 1'b0;
            busA.mem_data_ok = 1'b0;
            busA.mem_rdata = 32'hBAD0_BAD0;
            if (respPhase == 0) begin
                if (busA.mem_req) begin
                    if (respCnt >= respAddrLat) begin
                        busA.mem_addr_ok = 1'b1;
                        respAddr = busA.mem_addr;
                        respPhase = 1;
                        respCnt = 0;
                    end else begin
                        respCnt++;
                    end
                end else begin
                    respCnt = 0;
                end
            end else if (respNoData != 0) begin
                respPhase = 0;
            end else if (respCnt >= respDataLat) begin
                busA.mem_data_ok = 1'b1;
                busA.mem_rdata = memModel(respAddr);
                respPhase = 0;
                respCnt = 0;
                dataOkCount++;
            end else begin
                respCnt++;
            end
        end
    end

    // Scoreboard for instance A, sampled just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            checkOutput("stallIfA", busA.stall_req_if, busA.if_req & ~busA.if_done);
            checkOutput("stallMemA", busA.stall_req_mem, busA.d_req & ~busA.d_done);
            if (busA.mem_req && !prevReqA) begin
                if (grantQA.size() == 0) begin
                    checkOutput("spuriousGrantA", busA.mem_req, 0);
                end else begin
                    grantT g;
                    g = grantQA.pop_front();
                    checkOutput("grantAddrA", busA.mem_addr, g.addr);
                    checkOutput("grantWenA", busA.mem_wen, g.wen);
                    if (g.wen != 4'h0) checkOutput("grantWdataA", busA.mem_wdata, g.wdata);
                end
            end
            if (busA.if_done) begin
                ifDoneSeenA++;
                checkOutput("ifPulseA", prevIfDoneA, 0);
                if (ifDoneQA.size() == 0) begin
                    checkOutput("spuriousIfDoneA", busA.if_done, 0);
                end else begin
                    doneT e;
                    e = ifDoneQA.pop_front();
                    if (e.checkData) checkOutput("ifRdataA", busA.if_rdata, e.rdata);
                    checkOutput("ifBusErrA", busA.bus_err, e.busErr);
                end
            end
            if (busA.d_done) begin
                checkOutput("dPulseA", prevDDoneA, 0);
                if (dDoneQA.size() == 0) begin
                    checkOutput("spuriousDDoneA", busA.d_done, 0);
                end else begin
                    doneT e;
                    e = dDoneQA.pop_front();
                    if (e.checkData) checkOutput("dRdataA", busA.d_rdata, e.rdata);
                    checkOutput("dBusErrA", busA.bus_err, e.busErr);
                end
            end
        end
        prevReqA = busA.mem_req;
        prevIfDoneA = busA.if_done;
        prevDDoneA = busA.d_done;
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (busB.mem_req && !prevReqB) begin
                if (grantQB.size() == 0) begin
                    checkOutput("spuriousGrantB", busB.mem_req, 0);
                end else begin
                    grantT g;
                    g = grantQB.pop_front();
                    checkOutput("grantAddrB", busB.mem_addr, g.addr);
                end
            end
            if (busB.if_done) begin
                if (ifDoneQB.size() == 0) checkOutput("spuriousIfDoneB", busB.if_done, 0);
                else checkOutput("ifRdataB", busB.if_rdata, ifDoneQB.pop_front().rdata);
            end
            if (busB.d_done) begin
                if (dDoneQB.size() == 0) checkOutput("spuriousDDoneB", busB.d_done, 0);
                else checkOutput("dRdataB", busB.d_rdata, dDoneQB.pop_front().rdata);
            end
        end
        prevReqB = busB.mem_req;
    end

    // Requesters hold req through the done cycle and drop it on the following falling edge.
    task automatic reqDataA(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                            input bit expErr, output int lat);
        doneT e;
        e.rdata = expErr ? 32'h0 : memModel(addr);
        e.checkData = (wen == 4'h0);
        e.busErr = expErr;
        dDoneQA.push_back(e);
        busA.d_req = 1'b1; busA.d_addr = addr; busA.d_wen = wen; busA.d_wdata = wdata;
        lat = 0;
        while (!busA.d_done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!busA.d_done) checkOutput("dDoneWaitA", busA.d_done, 1);
        @(negedge clk);
        busA.d_req = 1'b0;
    endtask

    task automatic reqFetchA(input logic [31:0] addr, output int lat);
        doneT e;
        e.rdata = memModel(addr);
        e.checkData = 1'b1;
        e.busErr = 1'b0;
        ifDoneQA.push_back(e);
        busA.if_req = 1'b1; busA.if_addr = addr;
        lat = 0;
        while (!busA.if_done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!busA.if_done) checkOutput("ifDoneWaitA", busA.if_done, 1);
        @(negedge clk);
        busA.if_req = 1'b0;
    endtask

    task automatic reqB(input bit isData, input logic [31:0] addr, output int lat);
        doneT e;
        e.rdata = 32'hC0DE_0000;
        e.checkData = 1'b1;
        e.busErr = 1'b0;
        lat = 0;
        if (isData) begin
            dDoneQB.push_back(e);
            busB.d_req = 1'b1; busB.d_addr = addr; busB.d_wen = 4'h0;
            while (!busB.d_done && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            if (!busB.d_done) checkOutput("dDoneWaitB", busB.d_done, 1);
            @(negedge clk);
            busB.d_req = 1'b0;
        end else begin
            ifDoneQB.push_back(e);
            busB.if_req = 1'b1; busB.if_addr = addr;
            while (!busB.if_done && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            if (!busB.if_done) checkOutput("ifDoneWaitB", busB.if_done, 1);
            @(negedge clk);
            busB.if_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int latD, latI, base, doneBase;
        rst = 1'b1;
        busA.flush = 0; busA.if_req = 0; busA.if_addr = 0; busA.d_req = 0;
        busA.d_wen = 0; busA.d_addr = 0; busA.d_wdata = 0;
        busA.mem_addr_ok = 0; busA.mem_data_ok = 0; busA.mem_rdata = 0;
        busB.flush = 0; busB.if_req = 0; busB.if_addr = 0; busB.d_req = 0;
        busB.d_wen = 0; busB.d_addr = 0; busB.d_wdata = 0;
        busB.mem_addr_ok = 1; busB.mem_data_ok = 1; busB.mem_rdata = 32'hC0DE_0000;
        respAddrLat = 0; respDataLat = 1; respNoData = 0;

        repeat (3) @(negedge clk);
        checkOutput("rstMemReqA", busA.mem_req, 0);
        checkOutput("rstIfDoneA", busA.if_done, 0);
        checkOutput("rstDDoneA", busA.d_done, 0);
        checkOutput("rstBusErrA", busA.bus_err, 0);
        checkOutput("rstDRdataA", busA.d_rdata, 0);
        checkOutput("rstIfRdataA", busA.if_rdata, 0);
        checkOutput("rstMemAddrA", busA.mem_addr, 0);
        checkOutput("rstMemWenA", busA.mem_wen, 0);
        checkOutput("rstMemReqB", busB.mem_req, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] read 0x100 with one data wait state");
        pushGrantA(32'h100, 4'h0, 32'h0);
        reqDataA(32'h100, 4'h0, 32'h0, 1'b0, latD);
        checkOutput("latRead", latD, 4);

        $display("[TB] store");
        pushGrantA(32'h104, 4'hF, 32'h1122_3344);
        reqDataA(32'h104, 4'hF, 32'h1122_3344, 1'b0, latD);
        checkOutput("latStore", latD, 4);

        $display("[TB] simultaneous requests after a data grant: fetch first");
        pushGrantA(32'h40, 4'h0, 32'h0);
        pushGrantA(32'h108, 4'h0, 32'h0);
        fork
            reqFetchA(32'h40, latI);
            reqDataA(32'h108, 4'h0, 32'h0, 1'b0, latD);
        join
        checkOutput("fairIfLat", latI, 4);
        checkOutput("fairDLat", latD, 8);

        $display("[TB] simultaneous requests after a fetch grant: data first");
        pushGrantA(32'h44, 4'h0, 32'h0);
        reqFetchA(32'h44, latI);
        pushGrantA(32'h10C, 4'h0, 32'h0);
        pushGrantA(32'h48, 4'h0, 32'h0);
        fork
            reqFetchA(32'h48, latI);
            reqDataA(32'h10C, 4'h0, 32'h0, 1'b0, latD);
        join
        checkOutput("fairDLat2", latD, 4);
        checkOutput("fairIfLat2", latI, 8);

        $display("[TB] flush in IF_ADDR before address accept");
        respAddrLat = 3;
        doneBase = ifDoneSeenA;
        base = dataOkCount;
        pushGrantA(32'h80, 4'h0, 32'h0);
        busA.if_req = 1'b1; busA.if_addr = 32'h80;
        @(negedge clk);
        checkOutput("flushAddrReqOn", busA.mem_req, 1);
        busA.flush = 1'b1; busA.if_req = 1'b0;
        @(negedge clk);
        busA.flush = 1'b0;
        checkOutput("flushAddrReqOff", busA.mem_req, 0);
        repeat (4) @(negedge clk);
        checkOutput("flushAddrNoDone", ifDoneSeenA - doneBase, 0);
        checkOutput("flushAddrNoBus", dataOkCount - base, 0);
        respAddrLat = 0;

        $display("[TB] flush in IF_DATA");
        respDataLat = 3;
        base = dataOkCount;
        pushGrantA(32'h84, 4'h0, 32'h0);
        busA.if_req = 1'b1; busA.if_addr = 32'h84;
        @(negedge clk);
        checkOutput("flushDataReqOn", busA.mem_req, 1);
        @(negedge clk);
        busA.flush = 1'b1; busA.if_req = 1'b0;
        @(negedge clk);
        busA.flush = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("flushDataBusDone", dataOkCount - base, 1);
        checkOutput("flushDataNoDone", ifDoneSeenA - doneBase, 0);
        respDataLat = 0;
        pushGrantA(32'h88, 4'h0, 32'h0);
        reqFetchA(32'h88, latI);
        checkOutput("postFlushLat", latI, 3);

        $display("[TB] flush in IDLE blocks the fetch grant");
        pushGrantA(32'h8C, 4'h0, 32'h0);
        busA.flush = 1'b1;
        fork
            reqFetchA(32'h8C, latI);
            begin
                @(negedge clk);
                checkOutput("flushIdleBlock", busA.mem_req, 0);
                busA.flush = 1'b0;
            end
        join
        checkOutput("flushIdleLat", latI, 4);

        $display("[TB] watchdog abort");
        respNoData = 1;
        pushGrantA(32'h200, 4'h0, 32'h0);
        reqDataA(32'h200, 4'h0, 32'h0, 1'b1, latD);
        checkOutput("timeoutLat", latD, 6);
        respNoData = 0;
        pushGrantA(32'h204, 4'h0, 32'h0);
        reqDataA(32'h204, 4'h0, 32'h0, 1'b0, latD);
        checkOutput("postTimeoutLat", latD, 3);

        $display("[TB] data-priority instance");
        pushGrantB(32'h300);
        reqB(1'b1, 32'h300, latD);
        checkOutput("prioSoloLat", latD, 3);
        pushGrantB(32'h304);
        pushGrantB(32'h500);
        fork
            reqB(1'b0, 32'h500, latI);
            reqB(1'b1, 32'h304, latD);
        join
        checkOutput("prioDLat", latD, 3);
        checkOutput("prioIfLat", latI, 6);

        repeat (4) @(negedge clk);
        checkOutput("grantQALeft", grantQA.size(), 0);
        checkOutput("ifDoneQALeft", ifDoneQA.size(), 0);
        checkOutput("dDoneQALeft", dDoneQA.size(), 0);
        checkOutput("grantQBLeft", grantQB.size(), 0);
        checkOutput("doneQBLeft", ifDoneQB.size() + dDoneQB.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
